// File: rtl/areset_seq_sync.sv
// Reset sequencer: asserts NUM_CH active-low resets asynchronously and releases
// them synchronously in order ch0..chN-1 after a sync chain, a hold time and a stagger.
module areset_seq_sync #(
  parameter int SYNC_STAGES       = 2,
  parameter int NUM_CH            = 3,
  parameter int MIN_ASSERT_CYCLES = 4,
  parameter int STAGGER_CYCLES    = 3
) (
  input  logic              clk,
  input  logic              async_rst_ni,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_no,
  output logic              rst_done_o,
  output logic [1:0]        state_o
);

  localparam int HW = $clog2((MIN_ASSERT_CYCLES > 2) ? MIN_ASSERT_CYCLES : 2);
  localparam int SW = $clog2((STAGGER_CYCLES > 2) ? STAGGER_CYCLES : 2);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [SW-1:0]          stag_q, stag_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [NUM_CH-1:0]      rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   rst_sync_s;

  assign rst_sync_s = sync_q[SYNC_STAGES-1];

  // Sync chain is never touched by the software reset, so sw resets skip its latency.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Next-state and output computation; software reset overrides all sequencing.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    done_d  = done_q;
    if (sw_rst_i) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      stag_d  = '0;
      ch_d    = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!rst_sync_s) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            rst_d[0] = 1'b1;
            hold_d   = '0;
            stag_d   = '0;
            ch_d     = CW'(1);
            if (NUM_CH == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RELEASE: begin
          if (stag_q == STAG_LAST) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (CW'(i) == ch_q) begin
                rst_d[i] = 1'b1;
              end else begin
                rst_d[i] = rst_q[i];
              end
            end
            stag_d = '0;
            ch_d   = ch_q + CW'(1);
            if (ch_q == CH_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            stag_d = stag_q + SW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_HOLD;
          hold_d  = '0;
          stag_d  = '0;
          ch_d    = '0;
          rst_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; async reset clears everything including the sync chain.
  always_ff @(posedge clk or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      hold_q  <= '0;
      stag_q  <= '0;
      ch_q    <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign rst_no     = rst_q;
  assign rst_done_o = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_areset_seq_sync.sv
// Self-checking bench for areset_seq_sync: default 3-channel instance plus a
// single-channel parameter-sweep instance.
module tb_areset_seq_sync;

  typedef struct {
    logic [2:0] rst;
    logic       done;
    logic [1:0] st;
    string      tag;
  } exp_t;

  typedef struct {
    logic       sw;
    logic [2:0] rst;
    logic       done;
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       async_rst_ni = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic [2:0] rst_no;
  logic       rst_done_o;
  logic [1:0] state_o;

  logic       async2_ni = 1'b0;
  logic       sw2 = 1'b0;
  logic [0:0] rst2_no;
  logic       done2;
  logic [1:0] state2;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  vec_t vec[11];

  always #5 clk = ~clk;

  areset_seq_sync dut (
    .clk(clk), .async_rst_ni(async_rst_ni), .sw_rst_i(sw_rst_i),
    .rst_no(rst_no), .rst_done_o(rst_done_o), .state_o(state_o)
  );

  areset_seq_sync #(.SYNC_STAGES(3), .NUM_CH(1), .MIN_ASSERT_CYCLES(1), .STAGGER_CYCLES(1)) dut2 (
    .clk(clk), .async_rst_ni(async2_ni), .sw_rst_i(sw2),
    .rst_no(rst2_no), .rst_done_o(done2), .state_o(state2)
  );

  // Expected outputs n edges after a sequence start whose ch0 release is at edge 'first'.
  function automatic exp_t exp_seq(input int n, input int first, input string tag);
    exp_t e;
    for (int i = 0; i < 3; i++) e.rst[i] = (n >= first + 3 * i);
    e.done = (n >= first + 6);
    e.st   = (n < first) ? 2'b00 : ((n >= first + 6) ? 2'b10 : 2'b01);
    e.tag  = tag;
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] r, input logic d, input logic [1:0] s, input string tag);
    exp_t e;
    e.rst = r; e.done = d; e.st = s; e.tag = tag;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    n_cmp++;
    if (rst_no !== e.rst || rst_done_o !== e.done || state_o !== e.st) begin
      n_fail++;
      $display("FAIL %s @%0t: got rst_no=%b done=%b state=%b, want rst_no=%b done=%b state=%b",
               e.tag, $time, rst_no, rst_done_o, state_o, e.rst, e.done, e.st);
    end
  endtask

  task automatic check_now(input exp_t e);
    sb_q.push_back(e);
    check_pop();
  endtask

  task automatic drive_edge(input logic sw, input exp_t e);
    sw_rst_i = sw;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic check2(input logic r, input logic d, input logic [1:0] s, input string tag);
    n_cmp++;
    if (rst2_no !== r || done2 !== d || state2 !== s) begin
      n_fail++;
      $display("FAIL %s @%0t: got rst_no=%b done=%b state=%b, want rst_no=%b done=%b state=%b",
               tag, $time, rst2_no, done2, state2, r, d, s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // sw pulse from DONE: edge j is entry 0
    vec[0]  = '{1'b1, 3'b000, 1'b0, 2'b00};
    vec[1]  = '{1'b0, 3'b000, 1'b0, 2'b00};
    vec[2]  = '{1'b0, 3'b000, 1'b0, 2'b00};
    vec[3]  = '{1'b0, 3'b000, 1'b0, 2'b00};
    vec[4]  = '{1'b0, 3'b001, 1'b0, 2'b01};
    vec[5]  = '{1'b0, 3'b001, 1'b0, 2'b01};
    vec[6]  = '{1'b0, 3'b001, 1'b0, 2'b01};
    vec[7]  = '{1'b0, 3'b011, 1'b0, 2'b01};
    vec[8]  = '{1'b0, 3'b011, 1'b0, 2'b01};
    vec[9]  = '{1'b0, 3'b011, 1'b0, 2'b01};
    vec[10] = '{1'b0, 3'b111, 1'b1, 2'b10};

    // 1: power-on reset, released mid-cycle
    #50;
    check_now(mk(3'b000, 1'b0, 2'b00, "por_low"));
    #50;
    async_rst_ni = 1'b1;
    for (int n = 0; n <= 11; n++) drive_edge(1'b0, exp_seq(n, 5, "por_seq"));

    // 3: one-cycle software reset from DONE
    for (int i = 0; i < 11; i++)
      drive_edge(vec[i].sw, mk(vec[i].rst, vec[i].done, vec[i].st, "sw_pulse"));

    // 4: software reset held for 5 cycles
    for (int i = 0; i < 5; i++) drive_edge(1'b1, mk(3'b000, 1'b0, 2'b00, "sw_held"));
    for (int n = 1; n <= 10; n++) drive_edge(1'b0, exp_seq(n, 4, "sw_held_seq"));

    // 5: software reset on the edge that would release ch1
    drive_edge(1'b1, mk(3'b000, 1'b0, 2'b00, "sw_pre"));
    for (int n = 1; n <= 6; n++) drive_edge(1'b0, exp_seq(n, 4, "sw_pre_seq"));
    drive_edge(1'b1, mk(3'b000, 1'b0, 2'b00, "sw_vs_ch1"));
    for (int n = 1; n <= 10; n++) drive_edge(1'b0, exp_seq(n, 4, "sw_vs_ch1_seq"));

    // 2: short async glitch while rst_no=001
    drive_edge(1'b1, mk(3'b000, 1'b0, 2'b00, "glitch_pre"));
    for (int n = 1; n <= 5; n++) drive_edge(1'b0, exp_seq(n, 4, "glitch_pre_seq"));
    async_rst_ni = 1'b0;
    #1;
    check_now(mk(3'b000, 1'b0, 2'b00, "glitch_async"));
    #2;
    async_rst_ni = 1'b1;
    for (int n = 0; n <= 11; n++) drive_edge(1'b0, exp_seq(n, 5, "glitch_seq"));

    // 6: single-channel sweep instance, power-on reset
    check2(1'b0, 1'b0, 2'b00, "p6_low");
    @(negedge clk);
    async2_ni = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      @(posedge clk);
      #1;
      check2((n >= 3), (n >= 3), (n >= 3) ? 2'b10 : 2'b00, "p6_seq");
      n_cmp++;
      if ($isunknown({rst2_no, done2, state2})) begin
        n_fail++;
        $display("FAIL p6_x @%0t: got %b%b%b, want no X", $time, rst2_no, done2, state2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
